pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the period/high-time counters and results (legal 4..24).
REQ-002 SHALL have port clk  input  1  system clock (HFOSC domain).
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port pwm_in  input  1  asynchronous PWM waveform to measure.
REQ-005 SHALL have port meas_valid  output  1  measurement available.
REQ-006 SHALL have port meas_ready  input  1  consumer accepts measurement.
REQ-007 SHALL have port meas_period  output  CNT_W  clk cycles between consecutive rising edges.
REQ-008 SHALL have port meas_high  output  CNT_W  clk cycles from rising edge to following falling edge.
REQ-009 SHALL have port overrun  output  1  sticky: a completed measurement was dropped.
REQ-010 SHALL have port stuck  output  1  input idle beyond counter range (timeout feature).

Function
REQ-011 SHALL pass pwm_in through a 2-flop synchronizer plus one edge-detect flop; edges are seen 2 clk after the input transition.
REQ-012 SHALL run an FSM with states IDLE, ARMED, HIGH, LOW.
REQ-013 IDLE -> ARMED when synchronized input is 0; ARMED -> HIGH on rise; HIGH -> LOW on fall; LOW -> HIGH on rise, completing a measurement.
REQ-014 SHALL hold cnt = 0 in the rise-detect cycle, then increment by 1 each clk.
REQ-015 SHALL latch high = cnt on fall detect, and period = cnt on the next rise detect (input high 3, low 5 cycles -> period 8, high 3).
REQ-016 SHALL assert meas_valid the cycle after the completing rise; a transfer occurs when meas_valid && meas_ready.
REQ-017 SHALL hold meas_period/meas_high stable while meas_valid && !meas_ready.
REQ-018 SHALL drop a measurement completing while meas_valid is held, and set overrun to 1.
REQ-019 Simultaneous transfer and completion in the same cycle SHALL load the new result, keep meas_valid = 1, and not set overrun.
REQ-020 SHALL keep measuring continuously; each completing rise also starts the next period (cnt = 0).
REQ-021 SHALL saturate cnt at 2^CNT_W-1, never wrapping.

Reset
REQ-022 rst_n low SHALL asynchronously force state IDLE, cnt 0, synchronizer flops 0, meas_valid 0, meas_period 0, meas_high 0, overrun 0, stuck 0.
REQ-023 Reset asserted mid-measurement SHALL discard it; after release no measurement SHALL complete before a full low-high-low-high sequence.

Configuration
REQ-024 With PWM_CAPTURE_TIMEOUT_EN defined, cnt reaching saturation in HIGH or LOW SHALL set stuck = 1 and return the FSM to IDLE, discarding the partial measurement.
REQ-025 Under PWM_CAPTURE_TIMEOUT_EN, stuck SHALL clear on the next detected rise.
REQ-026 Without PWM_CAPTURE_TIMEOUT_EN, stuck SHALL be tied 0, and a saturated count SHALL be reported as 2^CNT_W-1 in the next measurement.

Structure
REQ-027 SHALL place the FSM state enum and the default CNT_W constant in shared package pwm_capture_pkg.
REQ-028 SHALL implement the synchronizer and edge detect as sub-module sync_edge (outputs level, rise, fall).

Verification
REQ-029 Reset, then pwm_in high 3 / low 5 repeated, meas_ready = 1 -> meas_period 8, meas_high 3 from the second rise onward.
REQ-030 pwm_in high at reset release -> no meas_valid until after the first observed low then rise.
REQ-031 meas_ready = 0 across two complete periods -> first result held stable, overrun = 1, meas_valid stays 1.
REQ-032 CNT_W = 4, pwm_in held low 20 cycles then toggled:
- with macro: stuck = 1 after cnt hits 15, then 0 on the next rise.
- without macro: stuck = 0 and meas_period = 15.
REQ-033 rst_n pulsed low mid-HIGH -> all outputs 0 immediately, and the next result is a clean period.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - shared FSM state type and default counter width for pwm_capture
package pwm_capture_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// rtl/pwm_capture_sync_edge.sv - 2-flop synchronizer plus edge-detect flop for pwm_in
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period/high-time capture with valid/ready result; optional PWM_CAPTURE_TIMEOUT_EN
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             overrun,
    output logic             stuck
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             level;
    logic             rise;
    logic             fall;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] high_lat;
    logic [1:0]       settle;
    logic             capture_high;
    logic             complete;
    logic             go_stuck;
    logic             timeout_hit;
    logic             accept;

    sync_edge u_sync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    // cnt holds 0 in the rise cycle, so the true cycle count is always cnt + 1 (saturating)
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    assign accept  = !meas_valid || meas_ready;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        capture_high = 1'b0;
        complete     = 1'b0;
        go_stuck     = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                // wait until the synchronizer holds real samples, not reset zeros
                if (settle[1] && !level) begin
                    state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                cnt_nxt = '0;
                if (rise) begin
                    state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                cnt_nxt = cnt_inc;
                if (fall) begin
                    state_nxt    = ST_LOW;
                    capture_high = 1'b1;
                end else if (timeout_hit) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    go_stuck  = 1'b1;
                end
            end
            ST_LOW: begin
                cnt_nxt = cnt_inc;
                if (rise) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = '0;
                    complete  = 1'b1;
                end else if (timeout_hit) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    go_stuck  = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            settle   <= 2'd0;
            high_lat <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (!settle[1]) begin
                settle <= settle + 2'd1;
            end
            if (capture_high) begin
                high_lat <= cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_valid  <= 1'b0;
            meas_period <= '0;
            meas_high   <= '0;
            overrun     <= 1'b0;
        end else begin
            if (complete && accept) begin
                meas_valid  <= 1'b1;
                meas_period <= cnt_inc;
                meas_high   <= high_lat;
            end else if (meas_valid && meas_ready) begin
                meas_valid <= 1'b0;
            end
            if (complete && !accept) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef PWM_CAPTURE_TIMEOUT_EN
    logic stuck_q;

    assign timeout_hit = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuck_q <= 1'b0;
        end else if (rise) begin
            stuck_q <= 1'b0;
        end else if (go_stuck) begin
            stuck_q <= 1'b1;
        end
    end

    assign stuck = stuck_q;
`else
    assign timeout_hit = 1'b0;
    assign stuck       = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture (CNT_W 16 and 4)
module tb_pwm_capture;

    logic        clk;
    logic        rst_n;
    logic        pwm_in;
    logic        meas_ready;
    logic        meas_valid;
    logic [15:0] meas_period;
    logic [15:0] meas_high;
    logic        overrun;
    logic        stuck;

    logic        pwm4;
    logic        ready4;
    logic        valid4;
    logic [3:0]  period4;
    logic [3:0]  high4;
    logic        overrun4;
    logic        stuck4;

    int n_cmp;
    int n_err;

    pwm_capture #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwm_in      (pwm_in),
        .meas_valid  (meas_valid),
        .meas_ready  (meas_ready),
        .meas_period (meas_period),
        .meas_high   (meas_high),
        .overrun     (overrun),
        .stuck       (stuck)
    );

    pwm_capture #(.CNT_W(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwm_in      (pwm4),
        .meas_valid  (valid4),
        .meas_ready  (ready4),
        .meas_period (period4),
        .meas_high   (high4),
        .overrun     (overrun4),
        .stuck       (stuck4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // one PWM period; the completing rise of this pulse is latched at the 3rd edge, checked just after it
    task automatic pulse(input int hi, input int lo, input logic rdy3, input logic rdy_rest,
                         input logic chk_en, input logic exp_v, input int exp_p,
                         input int exp_h, input logic exp_o, input string tag);
        for (int k = 0; k < hi + lo; k++) begin
            pwm_in     = (k < hi);
            meas_ready = (k == 2) ? rdy3 : rdy_rest;
            step(1);
            if (k == 2 && chk_en) begin
                chk({tag, "_valid"}, meas_valid, exp_v);
                if (exp_v) begin
                    chk({tag, "_period"}, meas_period, exp_p);
                    chk({tag, "_high"}, meas_high, exp_h);
                end
                chk({tag, "_overrun"}, overrun, exp_o);
            end
        end
        meas_ready = rdy_rest;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        pwm_in     = 1'b0;
        meas_ready = 1'b1;
        pwm4       = 1'b0;
        ready4     = 1'b1;
        step(3);
        chk("rst_valid", meas_valid, 0);
        chk("rst_period", meas_period, 0);
        chk("rst_high", meas_high, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_stuck", stuck, 0);

        rst_n = 1'b1;
        step(5);

        // steady 3 high / 5 low, consumer always ready
        pulse(3, 5, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, "p1");
        pulse(3, 5, 1'b1, 1'b1, 1'b1, 1'b1, 8, 3, 1'b0, "p2");
        pulse(3, 5, 1'b1, 1'b1, 1'b1, 1'b1, 8, 3, 1'b0, "p3");
        pulse(3, 5, 1'b1, 1'b1, 1'b1, 1'b1, 8, 3, 1'b0, "p4");
        chk("p4_valid_drop", meas_valid, 0);

        // consumer stalls; result held
        pulse(2, 4, 1'b0, 1'b0, 1'b1, 1'b1, 8, 3, 1'b0, "p5");
        // transfer and completion on the same edge: new result, no overrun
        pulse(4, 4, 1'b1, 1'b0, 1'b1, 1'b1, 6, 2, 1'b0, "p6");
        // two completions dropped while stalled
        pulse(3, 5, 1'b0, 1'b0, 1'b1, 1'b1, 6, 2, 1'b1, "p7");
        pulse(3, 5, 1'b0, 1'b0, 1'b1, 1'b1, 6, 2, 1'b1, "p8");
        meas_ready = 1'b1;
        step(1);
        chk("drain_valid", meas_valid, 0);
        chk("drain_overrun", overrun, 1);

        // reset pulsed mid-HIGH, released with pwm_in still high
        pwm_in = 1'b1;
        step(5);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", meas_valid, 0);
        chk("midrst_period", meas_period, 0);
        chk("midrst_high", meas_high, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_stuck", stuck, 0);
        rst_n = 1'b1;
        step(6);
        chk("rel_high_valid", meas_valid, 0);
        pwm_in = 1'b0;
        step(6);
        chk("rel_low_valid", meas_valid, 0);
        pulse(3, 5, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, "r1");
        pulse(3, 5, 1'b1, 1'b1, 1'b1, 1'b1, 8, 3, 1'b0, "r2");

        // CNT_W = 4 instance: long low phase
        pwm4 = 1'b1;
        step(3);
        pwm4 = 1'b0;
        step(20);
`ifdef PWM_CAPTURE_TIMEOUT_EN
        chk("w4_stuck_set", stuck4, 1);
        chk("w4_valid_idle", valid4, 0);
`else
        chk("w4_stuck_tied", stuck4, 0);
        chk("w4_valid_idle", valid4, 0);
`endif
        pwm4 = 1'b1;
        step(3);
`ifdef PWM_CAPTURE_TIMEOUT_EN
        chk("w4_stuck_clear", stuck4, 0);
        chk("w4_valid_discard", valid4, 0);
`else
        chk("w4_valid", valid4, 1);
        chk("w4_period_sat", period4, 15);
        chk("w4_high", high4, 3);
        chk("w4_stuck_still", stuck4, 0);
`endif
        pwm4 = 1'b0;
        step(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
